// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Execute-stage ALU for an RV32I/RV64I core. It decodes ALUOp,
//            funct3, funct7 bits 30/25 and opcode bit 5. It computes the base
//            integer ALU set with one cycle of latency. With ALU_MEXT_EN
//            defined, it also runs the M-extension multiply/divide set on an
//            iterative one-bit-per-cycle datapath.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_valid/in_ready   - operand/opcode bundle handshake
//            ALUOp, funct3, funct7_5, funct7_0, op_5 - decode fields
//            srcA, srcB          - XLEN-bit operands
//            result, zero, illegal, out_valid/out_ready - registered output
//            busy                - iterative operation in progress
// Config   : ALU_MEXT_EN - compiles in the M-extension FSM and datapath.
//            Without it, an M encoding completes as illegal with result 0.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic            op_5,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy
);

    localparam int c_SHW = $clog2(XLEN);

    logic [XLEN-1:0]        r_result;
    logic                   r_zero;
    logic                   r_illegal;
    logic                   r_out_valid;

    logic                   w_busy;
    logic                   w_accept;
    logic                   w_is_m;
    logic                   w_m_path;
    logic                   w_base_ill;
    logic [c_SHW-1:0]       w_shamt;
    logic signed [XLEN-1:0] w_sra;
    logic [XLEN-1:0]        w_base_result;
    logic [XLEN-1:0]        w_base_out;

    assign w_is_m   = (ALUOp == 2'b10) && op_5 && funct7_0;
    assign in_ready = !w_busy && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_shamt  = srcB[c_SHW-1:0];
    // Kept in its own signed wire so the shift stays arithmetic.
    // Mixing it with unsigned operands in the mux would turn it logical.
    assign w_sra    = $signed(srcA) >>> w_shamt;

    always_comb begin
        w_base_result = srcA + srcB;
        case (ALUOp)
            2'b01: w_base_result = srcA - srcB;
            2'b10: begin
                case (funct3)
                    3'b000: w_base_result = (op_5 && funct7_5) ? (srcA - srcB) : (srcA + srcB);
                    3'b001: w_base_result = srcA << w_shamt;
                    3'b010: w_base_result = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
                    3'b011: w_base_result = {{(XLEN-1){1'b0}}, (srcA < srcB)};
                    3'b100: w_base_result = srcA ^ srcB;
                    3'b101: w_base_result = funct7_5 ? $unsigned(w_sra) : (srcA >> w_shamt);
                    3'b110: w_base_result = srcA | srcB;
                    default: w_base_result = srcA & srcB;
                endcase
            end
            default: w_base_result = srcA + srcB;
        endcase
    end

`ifdef ALU_MEXT_EN
    // ------------------------------------------------------------------
    // Iterative multiply / divide
    // ------------------------------------------------------------------
    localparam logic [1:0]       c_S_IDLE   = 2'd0;
    localparam logic [1:0]       c_S_LOAD   = 2'd1;
    localparam logic [1:0]       c_S_ITER   = 2'd2;
    localparam logic [1:0]       c_S_FIX    = 2'd3;
    localparam logic [c_SHW-1:0] c_CNT_LAST = {c_SHW{1'b1}};   // XLEN-1, XLEN is a power of two

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [2:0]          r_op;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [XLEN-1:0]     r_mcand;       // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   r_prod;        // mul: {acc, multiplier}; div: {rem, dividend/quotient}
    logic [c_SHW-1:0]    r_cnt;
    logic                r_neg_q;       // negate product / quotient at the end
    logic                r_neg_r;       // negate remainder at the end

    logic                w_sgn_a;
    logic                w_sgn_b;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_step;
    logic [XLEN:0]       w_div_shift;
    logic                w_div_ge;
    logic [XLEN-1:0]     w_div_diff;
    logic [2*XLEN-1:0]   w_div_step;
    logic [2*XLEN-1:0]   w_prod_s;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_m_result;

    assign w_m_path   = w_is_m;
    assign w_base_ill = 1'b0;
    assign w_busy     = (r_state != c_S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: if (w_accept && w_is_m) w_state_next = c_S_LOAD;
            c_S_LOAD: w_state_next = c_S_ITER;
            c_S_ITER: if (r_cnt == c_CNT_LAST) w_state_next = c_S_FIX;
            default:  w_state_next = c_S_IDLE;
        endcase
    end

    // Unsigned operands: MULHU/DIVU/REMU for A; those plus MULHSU for B.
    assign w_sgn_a = (r_op != 3'b011) && (r_op != 3'b101) && (r_op != 3'b111);
    assign w_sgn_b = w_sgn_a && (r_op != 3'b010);
    assign w_neg_a = w_sgn_a && r_a[XLEN-1];
    assign w_neg_b = w_sgn_b && r_b[XLEN-1];
    assign w_mag_a = w_neg_a ? (-r_a) : r_a;
    assign w_mag_b = w_neg_b ? (-r_b) : r_b;

    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole product right by one.
    assign w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_mul_step = {w_mul_sum, r_prod[XLEN-1:1]};

    // Restoring divide: shift the next dividend bit into the partial
    // remainder. Subtract when it fits, and shift the quotient bit in at
    // the bottom. A zero divisor always "fits", which yields the all-ones
    // quotient and leaves the dividend as the remainder.
    assign w_div_shift = r_prod[2*XLEN-1:XLEN-1];
    assign w_div_ge    = (w_div_shift >= {1'b0, r_mcand});
    assign w_div_diff  = w_div_shift[XLEN-1:0] - r_mcand;
    assign w_div_step  = {(w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0]), r_prod[XLEN-2:0], w_div_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept && w_is_m) begin
                        r_op <= funct3;
                        r_a  <= srcA;
                        r_b  <= srcB;
                    end
                end
                c_S_LOAD: begin
                    r_cnt   <= '0;
                    r_neg_r <= w_neg_a;
                    if (r_op[2]) begin
                        // Quotient keeps its sign only for a non-zero divisor.
                        r_neg_q <= (w_neg_a ^ w_neg_b) && (r_b != '0);
                        r_prod  <= {{XLEN{1'b0}}, w_mag_a};
                        r_mcand <= w_mag_b;
                    end else begin
                        r_neg_q <= w_neg_a ^ w_neg_b;
                        r_prod  <= {{XLEN{1'b0}}, w_mag_b};
                        r_mcand <= w_mag_a;
                    end
                end
                c_S_ITER: begin
                    r_cnt  <= r_cnt + c_SHW'(1);
                    r_prod <= r_op[2] ? w_div_step : w_mul_step;
                end
                default: ;
            endcase
        end
    end

    assign w_prod_s = r_neg_q ? (-r_prod) : r_prod;
    assign w_quo    = r_prod[XLEN-1:0];
    assign w_rem    = r_prod[2*XLEN-1:XLEN];

    always_comb begin
        w_m_result = w_prod_s[XLEN-1:0];
        case (r_op)
            3'b000:          w_m_result = w_prod_s[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:          w_m_result = w_prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:  w_m_result = r_neg_q ? (-w_quo) : w_quo;
            default:         w_m_result = r_neg_r ? (-w_rem) : w_rem;
        endcase
    end
`else
    // No multiply/divide hardware: an M encoding finishes as a base op.
    assign w_m_path   = 1'b0;
    assign w_base_ill = w_is_m;
    assign w_busy     = 1'b0;
`endif

    assign w_base_out = w_base_ill ? '0 : w_base_result;

    // Output register. An accept is only possible when the slot is empty or
    // being retired this cycle. The FIX write cannot collide with unconsumed
    // data, because out_valid was cleared when the M op was accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept && !w_m_path) begin
            r_result    <= w_base_out;
            r_zero      <= (w_base_out == '0);
            r_illegal   <= w_base_ill;
            r_out_valid <= 1'b1;
        end
`ifdef ALU_MEXT_EN
        else if (r_state == c_S_FIX) begin
            r_result    <= w_m_result;
            r_zero      <= (w_m_result == '0);
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
        end
`endif
        else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;
    assign out_valid = r_out_valid;
    assign busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : Directed, self-checking bench for alu_exec_unit (XLEN = 32).
//            Expected results are queued when a bundle is accepted. They are
//            popped and compared when the unit retires a result.
//            The M-extension steps are selected by ALU_MEXT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      ALUOp;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic            funct7_0;
    logic            op_5;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic            out_valid;
    logic            out_ready;
    logic            busy;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOp     (ALUOp),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .funct7_0  (funct7_0),
        .op_5      (op_5),
        .srcA      (srcA),
        .srcB      (srcB),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic            zero;
        logic            ill;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    exp_t  cur_exp;
    string cur_tag;
    int    checks = 0;
    int    errors = 0;
    logic  accepted;
    int    last_wait;
    logic  busy_seen = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic retire();
        exp_t  e;
        string t;
        checks = checks + 1;
        assert (exp_q.size() != 0) else begin
            errors = errors + 1;
            $error("FAIL unexpected_output observed=0x%0h expected=no_output", result);
        end
        if (exp_q.size() != 0) begin
            checks = checks - 1;   // the three field compares below stand in for this one
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk({t, "_result"},  {32'h0, result},  {32'h0, e.res});
            chk({t, "_zero"},    {63'h0, zero},    {63'h0, e.zero});
            chk({t, "_illegal"}, {63'h0, illegal}, {63'h0, e.ill});
        end
    endtask

    // One clock: sample just after the negedge, record handshakes that
    // will complete at the coming posedge, then advance to the next negedge.
    task automatic tick();
        #1;
        if (busy === 1'b1) busy_seen = 1'b1;
        if (out_valid === 1'b1 && out_ready === 1'b1) retire();
        accepted = (in_valid === 1'b1) && (in_ready === 1'b1);
        if (accepted) begin
            exp_q.push_back(cur_exp);
            tag_q.push_back(cur_tag);
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] aop, input logic [2:0] f3, input logic f75,
                         input logic f70, input logic o5, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] er,
                         input logic eill, input string tag);
        ALUOp    = aop;
        funct3   = f3;
        funct7_5 = f75;
        funct7_0 = f70;
        op_5     = o5;
        srcA     = a;
        srcB     = b;
        in_valid = 1'b1;
        cur_exp.res  = er;
        cur_exp.zero = (er == '0);
        cur_exp.ill  = eill;
        cur_tag      = tag;
        accepted  = 1'b0;
        last_wait = 0;
        while (!accepted && last_wait < 100) begin
            tick();
            last_wait = last_wait + 1;
        end
        if (!accepted) begin
            checks = checks + 1;
            errors = errors + 1;
            $error("FAIL %s_accept observed=timeout expected=accept", tag);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n = n + 1;
        end
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   tp;
        logic tp_bad;
        logic hold_bad;
        int   lat;
        logic stall_bad;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        ALUOp = 2'b00; funct3 = 3'b000; funct7_5 = 1'b0; funct7_0 = 1'b0; op_5 = 1'b0;
        srcA = '0; srcB = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_result",    {32'h0, result},    64'd0);
        chk("rst_zero",      {63'h0, zero},      64'd0);
        chk("rst_illegal",   {63'h0, illegal},   64'd0);
        chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("rst_busy",      {63'h0, busy},      64'd0);
        chk("rst_in_ready",  {63'h0, in_ready},  64'd1);
        @(negedge clk);

        // Base ops: single issue with latency check
        issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, "add");
        #1;
        chk("add_latency", {63'h0, out_valid}, 64'd1);
        wait_empty("add");
        issue(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd7, 32'd7, 32'd0, 1'b0, "sub_rtype");
        #1;
        chk("sub_latency", {63'h0, out_valid}, 64'd1);
        issue(2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 32'd10, 32'd3, 32'd13, 1'b0, "addi_f7_ignored");
        issue(2'b01, 3'b111, 1'b0, 1'b0, 1'b0, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, "aluop_sub");
        issue(2'b11, 3'b001, 1'b1, 1'b1, 1'b1, 32'd2, 32'd3, 32'd5, 1'b0, "aluop_rsvd");
        wait_empty("misc");

        // Back-to-back throughput: each bundle accepted on its first cycle
        tp = 0;
        tp_bad = 1'b0;
        issue(2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, "sra");
        tp = tp + last_wait;
        issue(2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'd4, 32'h08000000, 1'b0, "srl");
        tp = tp + last_wait;
        if (out_valid !== 1'b1) tp_bad = 1'b1;
        issue(2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, "slt");
        tp = tp + last_wait;
        if (out_valid !== 1'b1) tp_bad = 1'b1;
        issue(2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, "sltu");
        tp = tp + last_wait;
        if (out_valid !== 1'b1) tp_bad = 1'b1;
        issue(2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1'b0, "xor");
        tp = tp + last_wait;
        issue(2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 32'hF0F00000, 32'h0000F0F0, 32'hF0F0F0F0, 1'b0, "or");
        tp = tp + last_wait;
        issue(2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, "and");
        tp = tp + last_wait;
        issue(2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'd1, 32'h3F, 32'h80000000, 1'b0, "sll_masked");
        tp = tp + last_wait;
        chk("b2b_issue_cycles", 64'(tp), 64'd8);
        chk("b2b_out_valid_cont", {63'h0, tp_bad}, 64'd0);
        wait_empty("b2b");

        // Backpressure: result held while out_ready is low, then retire+accept together
        out_ready = 1'b0;
        issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd2, 1'b0, "bp_first");
        hold_bad = 1'b0;
        repeat (5) begin
            #1;
            if (result !== 32'd2 || out_valid !== 1'b1 || in_ready !== 1'b0) hold_bad = 1'b1;
            tick();
        end
        chk("bp_hold_stable", {63'h0, hold_bad}, 64'd0);
        out_ready = 1'b1;
        issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0, "bp_second");
        chk("bp_same_cycle_accept", 64'(last_wait), 64'd1);
        wait_empty("bp");

`ifdef ALU_MEXT_EN
        // Multiply with latency and stall check
        issue(2'b10, 3'b001, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0, "mulh");
        lat = 0;
        stall_bad = 1'b0;
        #1;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) stall_bad = 1'b1;
            @(negedge clk);
            #1;
            lat = lat + 1;
        end
        chk("mulh_latency", 64'(lat), 64'd34);
        chk("mulh_busy_stall", {63'h0, stall_bad}, 64'd0);
        wait_empty("mulh");
        issue(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 1'b0, "mul");
        wait_empty("mul");
        issue(2'b10, 3'b011, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "mulhu");
        wait_empty("mulhu");
        issue(2'b10, 3'b010, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "mulhsu");
        wait_empty("mulhsu");

        // Divide, including corner cases
        issue(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b0, "div_by0");
        wait_empty("div_by0");
        issue(2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'd7, 32'd0, 32'd7, 1'b0, "rem_by0");
        wait_empty("rem_by0");
        issue(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, "div_ovf");
        wait_empty("div_ovf");
        issue(2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, "rem_ovf");
        wait_empty("rem_ovf");
        issue(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, "div_neg");
        wait_empty("div_neg");
        issue(2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, "rem_neg");
        wait_empty("rem_neg");
        issue(2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0, "divu");
        wait_empty("divu");
        issue(2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7, 32'd2, 1'b0, "remu");
        wait_empty("remu");

        // Reset in the middle of an iteration abandons it
        issue(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0, "div_abort");
        repeat (10) tick();
        rst = 1'b1;
        tick();
        #1;
        chk("abort_result",    {32'h0, result},    64'd0);
        chk("abort_out_valid", {63'h0, out_valid}, 64'd0);
        chk("abort_busy",      {63'h0, busy},      64'd0);
        chk("abort_zero",      {63'h0, zero},      64'd0);
        exp_q.delete();
        tag_q.delete();
        rst = 1'b0;
        repeat (40) tick();
        #1;
        chk("abort_no_stale", {63'h0, out_valid}, 64'd0);
`else
        // No M hardware: M encodings complete as illegal with base latency
        issue(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd6, 32'd7, 32'd0, 1'b1, "mul_noext");
        #1;
        chk("mul_noext_latency", {63'h0, out_valid}, 64'd1);
        chk("mul_noext_busy",    {63'h0, busy},      64'd0);
        issue(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'd7, 32'd0, 32'd0, 1'b1, "div_noext");
        wait_empty("noext");
        chk("busy_never_set", {63'h0, busy_seen}, 64'd0);
`endif

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute-stage unit for the RV32I/RV64I core. It decodes `funct3`, `funct7` bits, `op_5` and the 2-bit `ALUOp` from the main control. It executes the full base integer ALU set and, optionally, the M-extension multiply/divide set through an iterative datapath. Operands enter and results leave through valid/ready handshakes, so the pipeline can stall on multi-cycle operations.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; power of two, ≥ 8.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand/opcode bundle valid.
- `in_ready`  out  1  unit can accept a bundle this cycle.
- `ALUOp`  in  2  00 add, 01 sub, 10 decode funct fields, 11 reserved.
- `funct3`  in  3  instruction funct3.
- `funct7_5`  in  1  instruction bit 30.
- `funct7_0`  in  1  instruction bit 25 (M-extension select).
- `op_5`  in  1  opcode bit 5 (1 = R-type).
- `srcA`, `srcB`  in  XLEN  operands.
- `result`  out  XLEN  registered result.
- `zero`  out  1  `result == 0`, registered with `result`.
- `illegal`  out  1  bundle decoded to an unsupported op.
- `out_valid`  out  1  `result`/`zero`/`illegal` valid.
- `out_ready`  in  1  consumer takes the result.
- `busy`  out  1  iterative operation in progress.

## Operation
- Accept when `in_valid & in_ready`, where `in_ready = !busy & (!out_valid | out_ready)`.
- Base decode:
  - ALUOp 00 → ADD; 01 → SUB; 11 → ADD, `illegal`=0.
  - ALUOp 10, funct3: 000 SUB if `op_5&funct7_5` else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA if `funct7_5` else SRL; 110 OR; 111 AND.
- Shift amount is `srcB[$clog2(XLEN)-1:0]`. SLT/SLTU return 0 or 1, zero-extended. ADD/SUB wrap modulo 2^XLEN.
- M decode applies when ALUOp=10, `op_5`=1 and `funct7_0`=1. funct3 selects: 000 MUL (low XLEN), 001 MULH (s×s), 010 MULHSU (s×u), 011 MULHU (u×u), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- M datapath:
  - Operands are converted to magnitudes.
  - Iterative radix-2 shift-add multiply (2·XLEN product) or restoring divide, one bit per cycle.
  - The result sign is corrected at the end.
- Division corner cases:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = `srcA`.
  - Signed overflow (−2^(XLEN−1) ÷ −1): DIV = `srcA`, REM = 0.
  - Both cases still take the full iterative latency (data-independent timing).
- FSM:
  - IDLE → LOAD on accepting an M op.
  - LOAD → ITER (count = 0).
  - ITER → FIX after XLEN iterations.
  - FIX → IDLE, writing the output register.
- Base ops never leave IDLE.
- `busy` = state ≠ IDLE.
- The output register holds `result`/`zero`/`illegal` and keeps `out_valid` high until `out_ready`. A new result never overwrites an unconsumed one.
- Simultaneous `out_ready` and a new accept: the old result retires and the new bundle is accepted in the same cycle.

## Timing
- Reset values: `result`=0, `zero`=0, `illegal`=0, `out_valid`=0, `busy`=0, FSM=IDLE. `in_ready` is therefore 1 in the first cycle after reset.
- Base op: accept edge N → `out_valid`=1 after edge N+1 (1-cycle latency). Throughput is 1 per cycle when `out_ready` stays high.
- M op: accept edge N → `out_valid` after edge N+XLEN+2 (1 load, XLEN iterate, 1 fix). `in_ready`=0 throughout.
- `rst` mid-operation abandons the iteration and clears all outputs on that edge. No result is produced.
- `in_valid` while `in_ready`=0 is ignored; the producer holds the bundle.

## Configuration
- `ALU_MEXT_EN` defined: M-extension decode, FSM and iterative datapath are compiled in as above.
- Not defined:
  - No FSM or multiply/divide datapath; `busy` is tied to 0.
  - A bundle matching the M decode completes with base latency: `result`=0, `zero`=1, `illegal`=1.

## Test plan
- Reset and base ops, XLEN=32:
  - Reset, then ADD 5+7 → `result`=12 one cycle after accept, `zero`=0.
  - SUB (ALUOp 10, op_5=1, funct7_5=1) 7−7 → 0, `zero`=1.
- Shifts, compares and back-to-back throughput:
  - SRA 0x80000000 by 4 → 0xF8000000; SRL same → 0x08000000; SLT −1<1 → 1; SLTU → 0.
  - Back-to-back issue yields one result per cycle.
- Multiply (`ALU_MEXT_EN`):
  - MULH −2×3 → 0xFFFFFFFF; MUL → 0xFFFFFFFA; `out_valid` exactly 34 cycles after accept.
  - `in_ready`=0 and `busy`=1 in between.
- Divide corner cases:
  - DIV 7÷0 → 0xFFFFFFFF, REM → 7.
  - DIV 0x80000000÷−1 → 0x80000000, REM → 0.
  - DIV −7÷2 → −3, REM → −1.
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles: `result` stable, `in_ready`=0. Release with a new `in_valid` the same cycle: both retire and accept occur.
  - Assert `rst` at iteration 10 → all outputs 0 next cycle, no stale result.
- `ALU_MEXT_EN` undefined: MUL encoding → `illegal`=1, `result`=0, 1-cycle latency, `busy` never 1.
